// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC hit sequencer: FSM state encoding,
// fine-code width and the thermometer-code bubble check.
package tdc_pkg;

    localparam int MAX_TAPS = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ENCODE,
        ST_OUTPUT,
        ST_DEAD
    } tdc_state_t;

    function automatic int fine_width(input int ntaps);
        return $clog2(ntaps + 1);
    endfunction

    // A clean code with 'fine' ones is exactly the low 'fine' bits set.
    function automatic logic therm_bubble(input logic [MAX_TAPS-1:0] code,
                                          input int unsigned         fine);
        logic [MAX_TAPS-1:0] mask;
        for (int unsigned i = 0; i < MAX_TAPS; i++) begin
            mask[i] = (i < fine);
        end
        return code != mask;
    endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Combinational thermometer encoder: popcount of the captured taps plus a
// flag for codes that are not a clean thermometer pattern.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter  int NTAPS  = 16,
    localparam int FINE_W = fine_width(NTAPS)
) (
    input  logic [NTAPS-1:0]  taps,
    output logic [FINE_W-1:0] fine,
    output logic              bubble
);

    always_comb begin
        fine = '0;
        for (int i = 0; i < NTAPS; i++) begin
            fine = fine + FINE_W'(taps[i]);
        end
        bubble = therm_bubble(MAX_TAPS'(taps), 32'(fine));
    end

endmodule

// File: rtl/tdc_hit_sequencer.sv
// TDC hit sequencer: detects rising edges on the first delay-line tap, latches
// the tap code and coarse time, encodes it and hands it off over valid/ready.
module tdc_hit_sequencer
    import tdc_pkg::*;
#(
    parameter  int NTAPS    = 16,
    parameter  int COARSE_W = 16,
    parameter  int DEAD_CYC = 4,
    localparam int FINE_W   = fine_width(NTAPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NTAPS-1:0]    taps,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_bubble,
    output logic                ts_lost,
    output logic                busy
);

    tdc_state_t          state, state_next;
    logic [COARSE_W-1:0] coarse, coarse_lat;
    logic [NTAPS-1:0]    tap_lat;
    logic [3:0]          dead_cnt;
    logic                prev_tap0;
    logic                lost_flag, lost_late;
    logic                hit, lost_hit, accept;
    logic [FINE_W-1:0]   enc_fine;
    logic                enc_bubble;

    assign hit      = taps[0] & ~prev_tap0;
    assign lost_hit = hit && (state inside {ST_ENCODE, ST_OUTPUT, ST_DEAD});
    assign accept   = (state == ST_OUTPUT) && ts_ready;

    tdc_therm_encoder #(.NTAPS(NTAPS)) u_enc (
        .taps   (tap_lat),
        .fine   (enc_fine),
        .bubble (enc_bubble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (enable) state_next = ST_ARMED;
            ST_ARMED:  if (!enable) state_next = ST_IDLE;
                       else if (hit) state_next = ST_ENCODE;
            ST_ENCODE: state_next = enable ? ST_OUTPUT : ST_IDLE;
            ST_OUTPUT: if (ts_ready) state_next = enable ? ST_DEAD : ST_IDLE;
            ST_DEAD:   if (!enable) state_next = ST_IDLE;
                       else if (dead_cnt == '0) state_next = ST_ARMED;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse     <= '0;
            coarse_lat <= '0;
            tap_lat    <= '0;
            dead_cnt   <= '0;
            prev_tap0  <= 1'b0;
            lost_flag  <= 1'b0;
            lost_late  <= 1'b0;
            ts_valid   <= 1'b0;
            ts_coarse  <= '0;
            ts_fine    <= '0;
            ts_bubble  <= 1'b0;
            ts_lost    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            prev_tap0 <= taps[0];
            busy      <= !(state_next inside {ST_IDLE, ST_ARMED});
            if (enable) coarse <= coarse + COARSE_W'(1);

            if (state == ST_ARMED && enable && hit) begin
                tap_lat    <= taps;
                coarse_lat <= coarse;
            end

            if (state == ST_ENCODE && enable) begin
                ts_valid  <= 1'b1;
                ts_coarse <= coarse_lat;
                ts_fine   <= enc_fine;
                ts_bubble <= enc_bubble;
                ts_lost   <= lost_flag;
            end

            if (accept) begin
                ts_valid <= 1'b0;
                dead_cnt <= 4'(DEAD_CYC - 1);
            end else if (state == ST_DEAD) begin
                dead_cnt <= dead_cnt - 4'd1;
            end

            // Hits dropped after this timestamp was encoded must survive its acceptance.
            if (state == ST_ARMED && hit)
                lost_late <= 1'b0;
            else if (lost_hit && state != ST_DEAD)
                lost_late <= 1'b1;

            if (accept)
                lost_flag <= lost_late | lost_hit;
            else if (lost_hit)
                lost_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Directed self-checking bench for tdc_hit_sequencer (default build plus a
// COARSE_W=4 build for coarse wrap behaviour).
module tb_tdc_hit_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, en4;
    logic [15:0] taps, taps4;
    logic        ts_ready, rdy4;
    logic        ts_valid, v4;
    logic [15:0] ts_coarse;
    logic [3:0]  c4;
    logic [4:0]  ts_fine, f4;
    logic        ts_bubble, b4, ts_lost, l4, busy, busy4;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_coarse;
    logic [3:0]  exp_c4;
    logic [15:0] cap;
    logic [3:0]  cap4;

    always #5 clk = ~clk;

    tdc_hit_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .taps(taps),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
        .ts_fine(ts_fine), .ts_bubble(ts_bubble), .ts_lost(ts_lost), .busy(busy)
    );

    tdc_hit_sequencer #(.COARSE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .taps(taps4),
        .ts_valid(v4), .ts_ready(rdy4), .ts_coarse(c4),
        .ts_fine(f4), .ts_bubble(b4), .ts_lost(l4), .busy(busy4)
    );

    // Reference coarse counters, independent of the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_coarse <= '0;
            exp_c4     <= '0;
        end else begin
            if (enable) exp_coarse <= exp_coarse + 16'd1;
            if (en4)    exp_c4     <= exp_c4 + 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ts_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(ts_valid), 1);
    endtask

    // Present a rising edge on taps[0]; cap records the coarse time of the hit cycle.
    task automatic do_hit(input logic [15:0] pat);
        @(negedge clk);
        taps = pat;
        cap  = exp_coarse;
        @(negedge clk);
    endtask

    task automatic accept_and_idle(input logic [15:0] hold);
        @(negedge clk);
        ts_ready = 1'b1;
        @(negedge clk);
        ts_ready = 1'b0;
        taps     = hold;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; en4 = 1'b0;
        taps = '0; taps4 = '0; ts_ready = 1'b0; rdy4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid",  32'(ts_valid),  0);
        check("rst_coarse", 32'(ts_coarse), 0);
        check("rst_fine",   32'(ts_fine),   0);
        check("rst_bubble", 32'(ts_bubble), 0);
        check("rst_lost",   32'(ts_lost),   0);
        check("rst_busy",   32'(busy),      0);
        rst_n = 1'b1;

        // Clean 8-tap code at coarse 100, with the two-cycle latency checked.
        @(negedge clk);
        enable = 1'b1;
        while (exp_coarse != 16'd100) @(negedge clk);
        check("armed_busy", 32'(busy), 0);
        taps = 16'h00FF;
        @(negedge clk);
        check("lat_n1_valid", 32'(ts_valid), 0);
        check("encode_busy",  32'(busy),     1);
        @(negedge clk);
        check("lat_n2_valid", 32'(ts_valid),  1);
        check("t1_coarse",    32'(ts_coarse), 100);
        check("t1_fine",      32'(ts_fine),   8);
        check("t1_bubble",    32'(ts_bubble), 0);
        check("t1_lost",      32'(ts_lost),   0);
        accept_and_idle(16'h0000);
        check("t1_released", 32'(ts_valid), 0);

        // Bubbled and boundary codes.
        do_hit(16'h00F7);
        wait_valid("t2");
        check("t2_coarse", 32'(ts_coarse), 32'(cap));
        check("t2_fine",   32'(ts_fine),   7);
        check("t2_bubble", 32'(ts_bubble), 1);
        accept_and_idle(16'h0000);

        do_hit(16'hFFFF);
        wait_valid("t3");
        check("t3_fine",   32'(ts_fine),   16);
        check("t3_bubble", 32'(ts_bubble), 0);
        accept_and_idle(16'h0000);

        do_hit(16'h0001);
        wait_valid("t4");
        check("t4_fine",   32'(ts_fine),   1);
        check("t4_bubble", 32'(ts_bubble), 0);
        accept_and_idle(16'h0000);

        do_hit(16'h0101);
        wait_valid("t5");
        check("t5_fine",   32'(ts_fine),   2);
        check("t5_bubble", 32'(ts_bubble), 1);
        accept_and_idle(16'h0000);

        // Back-pressure with a second hit while the first timestamp waits.
        do_hit(16'h000F);
        wait_valid("t6");
        check("t6_coarse", 32'(ts_coarse), 32'(cap));
        taps = 16'h0000;
        @(negedge clk);
        taps = 16'h0003;
        @(negedge clk);
        taps = 16'h0000;
        repeat (7) @(negedge clk);
        check("t6_hold_valid",  32'(ts_valid),  1);
        check("t6_hold_coarse", 32'(ts_coarse), 32'(cap));
        check("t6_hold_fine",   32'(ts_fine),   4);
        check("t6_hold_lost",   32'(ts_lost),   0);
        accept_and_idle(16'h0000);

        do_hit(16'h003F);
        wait_valid("t7");
        check("t7_fine", 32'(ts_fine), 6);
        check("t7_lost", 32'(ts_lost), 1);
        accept_and_idle(16'h0000);

        do_hit(16'h0007);
        wait_valid("t8");
        check("t8_fine", 32'(ts_fine), 3);
        check("t8_lost", 32'(ts_lost), 0);

        // Taps held high through dead time must not retrigger.
        taps = 16'hFFFF;
        accept_and_idle(16'hFFFF);
        do_hit(16'hFFFF);
        repeat (6) @(negedge clk);
        check("stuck_no_valid", 32'(ts_valid), 0);
        check("stuck_armed",    32'(busy),     0);
        taps = 16'h0000;
        do_hit(16'h0003);
        wait_valid("t9");
        check("t9_fine", 32'(ts_fine), 2);
        check("t9_lost", 32'(ts_lost), 0);

        // Reset during a pending handshake.
        @(negedge clk);
        rst_n = 1'b0;
        taps  = 16'h0000;
        #1;
        check("mid_rst_valid",  32'(ts_valid),  0);
        check("mid_rst_coarse", 32'(ts_coarse), 0);
        check("mid_rst_fine",   32'(ts_fine),   0);
        check("mid_rst_busy",   32'(busy),      0);
        @(negedge clk);
        rst_n = 1'b1;
        en4   = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stale_valid", 32'(ts_valid), 0);

        // Coarse wrap on the 4-bit build.
        begin
            int n = 0;
            while (exp_c4 != 4'd15 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        taps4 = 16'h00FF;
        @(negedge clk);
        @(negedge clk);
        check("w_valid",  32'(v4), 1);
        check("w_coarse", 32'(c4), 15);
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4  = 1'b0;
        taps4 = 16'h0000;
        repeat (6) @(negedge clk);
        taps4 = 16'h0001;
        cap4  = exp_c4;
        @(negedge clk);
        @(negedge clk);
        check("w2_valid",  32'(v4), 1);
        check("w2_coarse", 32'(c4), 32'(cap4));
        check("w2_small",  32'(c4 < 4'd10), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
